// File: rtl/red_pitaya_asg_pkg.sv
// Shared definitions for the arbitrary signal generator buffer path.
// Holds the loader state encoding and the default buffer address width.
package red_pitaya_asg_pkg;

    localparam int ASG_RSZ = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } asg_ld_state_t;

endpackage

// File: rtl/red_pitaya_asg_buf_loader.sv
// Streams samples into the ASG sample buffer, one registered write per transfer.
// Supports one-shot and ring fills with an optional read-pointer collision guard.
module red_pitaya_asg_buf_loader
    import red_pitaya_asg_pkg::*;
#(
    parameter int RSZ = ASG_RSZ
)(
    input  logic           dac_clk_i,
    input  logic           dac_rst_i,
    input  logic           cfg_start_i,
    input  logic           cfg_abort_i,
    input  logic [RSZ-1:0] cfg_base_i,
    input  logic [RSZ:0]   cfg_len_i,
    input  logic           cfg_wrap_i,
    input  logic           cfg_guard_i,
    input  logic [RSZ-1:0] buf_rpnt_i,
    input  logic           s_valid_i,
    input  logic [13:0]    s_data_i,
    output logic           s_ready_o,
    output logic           buf_we_o,
    output logic [RSZ-1:0] buf_addr_o,
    output logic [13:0]    buf_wdata_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [RSZ:0]   wr_cnt_o
);

    localparam logic [RSZ-1:0] ADDR_ONE = {{(RSZ-1){1'b0}}, 1'b1};
    localparam logic [RSZ:0]   CNT_ONE  = {{RSZ{1'b0}}, 1'b1};
    localparam logic [RSZ:0]   CNT_MAX  = '1;

    asg_ld_state_t  state_q;
    asg_ld_state_t  state_d;
    logic [RSZ-1:0] base_q;
    logic [RSZ-1:0] addr_q;
    logic [RSZ:0]   len_q;
    logic [RSZ:0]   off_q;
    logic [RSZ:0]   cnt_q;
    logic           wrap_q;
    logic           guard_q;
    logic           last_q;
    logic           stall;
    logic           xfer;
    logic           at_last;
    logic           start_ok;

    // Ring mode must not overwrite the sample the DAC is about to read.
    assign stall     = guard_q & wrap_q & (addr_q == buf_rpnt_i);
    assign s_ready_o = (state_q == ST_RUN) & ~stall & ~last_q;
    assign xfer      = s_valid_i & s_ready_o;
    assign at_last   = (off_q == (len_q - CNT_ONE));
    assign start_ok  = (state_q == ST_IDLE) & cfg_start_i & ~cfg_abort_i;

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign wr_cnt_o = cnt_q;

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = (cfg_len_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_abort_i) begin
                    state_d = ST_IDLE;
                end else if (last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            buf_we_o    <= 1'b0;
            buf_addr_o  <= '0;
            buf_wdata_o <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            guard_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            buf_we_o <= xfer;
            if (xfer) begin
                buf_addr_o  <= addr_q;
                buf_wdata_o <= s_data_i;
            end
            if (start_ok) begin
                base_q  <= cfg_base_i;
                addr_q  <= cfg_base_i;
                len_q   <= cfg_len_i;
                wrap_q  <= cfg_wrap_i;
                guard_q <= cfg_guard_i;
                off_q   <= '0;
                cnt_q   <= '0;
                last_q  <= 1'b0;
            end else if (xfer) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
                if (at_last) begin
                    // One-shot: hold off ready until the final write lands.
                    if (wrap_q) begin
                        addr_q <= base_q;
                        off_q  <= '0;
                    end else begin
                        last_q <= 1'b1;
                    end
                end else begin
                    addr_q <= addr_q + ADDR_ONE;
                    off_q  <= off_q + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_asg_buf_loader.sv
// Scoreboard bench for the ASG buffer loader.
// Expected writes are queued at each transfer and popped on buf_we_o.
module tb_red_pitaya_asg_buf_loader;

    logic        clk = 1'b0;
    logic        dac_rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [13:0] cfg_base = '0;
    logic [14:0] cfg_len = '0;
    logic        cfg_wrap = 1'b0;
    logic        cfg_guard = 1'b0;
    logic [13:0] buf_rpnt = '0;
    logic        s_valid = 1'b0;
    logic [13:0] s_data = '0;
    logic        s_ready;
    logic        buf_we;
    logic [13:0] buf_addr;
    logic [13:0] buf_wdata;
    logic        busy;
    logic        done;
    logic [14:0] wr_cnt;

    red_pitaya_asg_buf_loader #(.RSZ(14)) dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (dac_rst),
        .cfg_start_i (cfg_start),
        .cfg_abort_i (cfg_abort),
        .cfg_base_i  (cfg_base),
        .cfg_len_i   (cfg_len),
        .cfg_wrap_i  (cfg_wrap),
        .cfg_guard_i (cfg_guard),
        .buf_rpnt_i  (buf_rpnt),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_ready_o   (s_ready),
        .buf_we_o    (buf_we),
        .buf_addr_o  (buf_addr),
        .buf_wdata_o (buf_wdata),
        .busy_o      (busy),
        .done_o      (done),
        .wr_cnt_o    (wr_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_we = 0;
    int n_done = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;

    logic [27:0] sb[$];
    logic [13:0] m_addr = '0;
    logic [13:0] m_base = '0;
    int          m_off = 0;
    int          m_len = 0;
    logic        m_wrap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [27:0] e;
        cyc++;
        if (buf_we) begin
            n_we++;
            last_we_cyc = cyc;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("waddr", {18'd0, buf_addr}, {18'd0, e[27:14]});
                chk("wdata", {18'd0, buf_wdata}, {18'd0, e[13:0]});
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (s_valid && s_ready) begin
            sb.push_back({m_addr, s_data});
            if (m_off == m_len - 1) begin
                if (m_wrap) begin
                    m_addr = m_base;
                    m_off  = 0;
                end
            end else begin
                m_addr = m_addr + 14'd1;
                m_off  = m_off + 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        s_data = 14'($urandom);
    endtask

    task automatic start_run(input logic [13:0] base, input int len,
                             input logic wrap, input logic guard);
        cfg_base  = base;
        cfg_len   = len[14:0];
        cfg_wrap  = wrap;
        cfg_guard = guard;
        cfg_start = 1'b1;
        m_base = base;
        m_addr = base;
        m_off  = 0;
        m_len  = len;
        m_wrap = wrap;
        n_we   = 0;
        n_done = 0;
        tick;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick;
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_we", {31'd0, buf_we}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {18'd0, buf_addr}, 32'd0);
        chk("rst_cnt", {17'd0, wr_cnt}, 32'd0);
        tick;
        dac_rst = 1'b0;
        tick;

        // abort wins over a coincident start
        cfg_len = 15'd4;
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        chk("start_abort_busy", {31'd0, busy}, 32'd0);

        // one-shot from 100; mid-run cfg changes and start are ignored
        s_valid = 1'b1;
        start_run(14'd100, 4, 1'b0, 1'b0);
        cfg_base  = 14'd7;
        cfg_len   = 15'd1;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        wait_done(20);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        tick;
        s_valid = 1'b0;
        tick;
        tick;
        chk("t1_writes", n_we, 4);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_done_lag", done_cyc - last_we_cyc, 1);
        chk("t1_wr_cnt", {17'd0, wr_cnt}, 32'd4);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_sb_empty", sb.size(), 0);

        // address rollover
        s_valid = 1'b1;
        start_run(14'h3ffe, 4, 1'b0, 1'b0);
        wait_done(20);
        tick;
        s_valid = 1'b0;
        tick;
        chk("t2_writes", n_we, 4);
        chk("t2_sb_empty", sb.size(), 0);

        // ring of 3, seven samples
        s_valid = 1'b1;
        start_run(14'd0, 3, 1'b1, 1'b0);
        repeat (7) tick;
        s_valid = 1'b0;
        tick;
        tick;
        chk("t3_writes", n_we, 7);
        chk("t3_no_done", n_done, 0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        chk("t3_wr_cnt", {17'd0, wr_cnt}, 32'd7);
        cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        tick;
        chk("t3_abort_idle", {31'd0, busy}, 32'd0);
        chk("t3_sb_empty", sb.size(), 0);

        // collision guard
        buf_rpnt = 14'd5;
        s_valid = 1'b1;
        start_run(14'd0, 8, 1'b1, 1'b1);
        repeat (10) tick;
        chk("t4_stalled_ready", {31'd0, s_ready}, 32'd0);
        chk("t4_stalled_writes", n_we, 5);
        buf_rpnt = 14'd6;
        repeat (4) tick;
        chk("t4_after_writes", n_we, 6);
        chk("t4_ready_again0", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        tick;
        chk("t4_sb_empty", sb.size(), 0);
        buf_rpnt = 14'd0;

        // zero length
        start_run(14'd20, 0, 1'b0, 1'b0);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        tick;
        chk("t5_done_gone", {31'd0, done}, 32'd0);
        chk("t5_writes", n_we, 0);
        chk("t5_cnt", {17'd0, wr_cnt}, 32'd0);

        // abort on the transfer at offset 2
        s_valid = 1'b1;
        start_run(14'd300, 8, 1'b0, 1'b0);
        tick;
        tick;
        cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        s_valid = 1'b0;
        repeat (3) tick;
        chk("t6_writes", n_we, 3);
        chk("t6_no_done", n_done, 0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_wr_cnt", {17'd0, wr_cnt}, 32'd3);
        chk("t6_sb_empty", sb.size(), 0);

        // reset while a write is in flight
        s_valid = 1'b1;
        start_run(14'd40, 8, 1'b0, 1'b0);
        tick;
        chk("t7_we_before", {31'd0, buf_we}, 32'd1);
        dac_rst = 1'b1;
        #1;
        chk("t7_we_async", {31'd0, buf_we}, 32'd0);
        chk("t7_busy_async", {31'd0, busy}, 32'd0);
        chk("t7_cnt_async", {17'd0, wr_cnt}, 32'd0);
        sb.delete();
        s_valid = 1'b0;
        tick;
        dac_rst = 1'b0;
        n_we = 0;
        tick;
        chk("t7_no_writes", n_we, 0);

        // first run after reset
        s_valid = 1'b1;
        start_run(14'd9, 2, 1'b0, 1'b0);
        wait_done(20);
        tick;
        s_valid = 1'b0;
        tick;
        chk("t8_writes", n_we, 2);
        chk("t8_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
